// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-memory and memory-side signals around the arbiter.
// slave = arbiter view, master = CPU pipeline plus memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              if_stall;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              dm_stall;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data memory,
// data memory first, with fetch granted in every data-complete cycle.
//
// state   | meaning
// IDLE    | no access in flight, arbitrating this cycle
// BUSY_IF | fetch in flight, counter runs down to read-data capture
// BUSY_DM | load/store in flight, counter runs down to completion
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LAT_LD = CW'(MEM_LAT);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              flush_q, flush_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              dm_valid_q, dm_valid_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flush_d     = flush_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // A requester whose valid is showing is still holding req; skip it once.
            if (bus.dm_req && !dm_valid_q) begin
               state_d     = BUSY_DM;
               cnt_d       = LAT_LD;
               mem_en_d    = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
            end else if (bus.if_req && !bus.if_flush && !if_valid_q) begin
               state_d    = BUSY_IF;
               cnt_d      = LAT_LD;
               flush_d    = 1'b0;
               mem_en_d   = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.if_addr;
            end
         end
         BUSY_IF: begin
            flush_d = flush_q | bus.if_flush;
            if (cnt_q == '0) begin
               state_d = IDLE;
               flush_d = 1'b0;
               if (!(flush_q || bus.if_flush)) begin
                  if_rdata_d = bus.mem_rdata;
                  if_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         BUSY_DM: begin
            if (cnt_q == '0) begin
               state_d    = IDLE;
               dm_valid_d = 1'b1;
               if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         flush_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         dm_valid_q  <= dm_valid_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dm_valid  = dm_valid_q;
   assign bus.if_stall  = bus.if_req && !if_valid_q;
   assign bus.dm_stall  = bus.dm_req && !dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for the main scenarios,
// MEM_LAT=1 instance for the short-latency sweep. Memory returns addr ^ 0x53.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   // Fixed-latency memories: data appears exactly LAT cycles after the mem_en cycle.
   logic        pa_en0 = 1'b0, pa_en1 = 1'b0, pb_en0 = 1'b0;
   logic [31:0] pa_ad0 = '0, pa_ad1 = '0, pb_ad0 = '0;
   always @(posedge clk) begin
      pa_en0 <= a_if.mem_en;
      pa_ad0 <= a_if.mem_addr;
      pa_en1 <= pa_en0;
      pa_ad1 <= pa_ad0;
      pb_en0 <= b_if.mem_en;
      pb_ad0 <= b_if.mem_addr;
   end
   assign a_if.mem_rdata = pa_en1 ? (pa_ad1 ^ 32'h53) : 32'hBAD0BAD0;
   assign b_if.mem_rdata = pb_en0 ? (pb_ad0 ^ 32'h53) : 32'hBAD0BAD0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      a_if.if_req = 0; a_if.if_addr = 0; a_if.if_flush = 0;
      a_if.dm_req = 0; a_if.dm_we = 0; a_if.dm_addr = 0; a_if.dm_wdata = 0;
      b_if.if_req = 0; b_if.if_addr = 0; b_if.if_flush = 0;
      b_if.dm_req = 0; b_if.dm_we = 0; b_if.dm_addr = 0; b_if.dm_wdata = 0;

      // Reset state
      tick(); tick();
      chk("rst_mem_en", a_if.mem_en, 0);
      chk("rst_mem_we", a_if.mem_we, 0);
      chk("rst_mem_addr", a_if.mem_addr, 0);
      chk("rst_mem_wdata", a_if.mem_wdata, 0);
      chk("rst_if_valid", a_if.if_valid, 0);
      chk("rst_dm_valid", a_if.dm_valid, 0);
      chk("rst_if_rdata", a_if.if_rdata, 0);
      chk("rst_dm_rdata", a_if.dm_rdata, 0);
      rst = 0;
      tick();

      // Lone fetch at 0x40
      a_if.if_req = 1; a_if.if_addr = 32'h40; #1;
      chk("s1_c0_if_stall", a_if.if_stall, 1);
      tick();
      chk("s1_c1_mem_en", a_if.mem_en, 1);
      chk("s1_c1_mem_addr", a_if.mem_addr, 32'h40);
      chk("s1_c1_mem_we", a_if.mem_we, 0);
      chk("s1_c1_if_stall", a_if.if_stall, 1);
      tick();
      chk("s1_c2_mem_en", a_if.mem_en, 0);
      tick();
      chk("s1_c3_if_valid", a_if.if_valid, 0);
      chk("s1_c3_if_stall", a_if.if_stall, 1);
      tick();
      chk("s1_c4_if_valid", a_if.if_valid, 1);
      chk("s1_c4_if_rdata", a_if.if_rdata, 32'h13);
      chk("s1_c4_if_stall", a_if.if_stall, 0);
      a_if.if_req = 0;
      tick();
      chk("s1_c5_if_valid", a_if.if_valid, 0);
      chk("s1_c5_mem_en", a_if.mem_en, 0);

      // Store and fetch together: store first, fetch granted in dm_valid cycle
      a_if.dm_req = 1; a_if.dm_we = 1; a_if.dm_addr = 32'h80; a_if.dm_wdata = 32'hDEAD;
      a_if.if_req = 1; a_if.if_addr = 32'h100;
      tick();
      chk("s2_c1_mem_en", a_if.mem_en, 1);
      chk("s2_c1_mem_we", a_if.mem_we, 1);
      chk("s2_c1_mem_addr", a_if.mem_addr, 32'h80);
      chk("s2_c1_mem_wdata", a_if.mem_wdata, 32'hDEAD);
      repeat (3) tick();
      chk("s2_c4_dm_valid", a_if.dm_valid, 1);
      chk("s2_c4_dm_rdata_kept", a_if.dm_rdata, 0);
      chk("s2_c4_dm_stall", a_if.dm_stall, 0);
      chk("s2_c4_if_stall", a_if.if_stall, 1);
      a_if.dm_req = 0;
      tick();
      chk("s2_c5_mem_en", a_if.mem_en, 1);
      chk("s2_c5_mem_addr", a_if.mem_addr, 32'h100);
      chk("s2_c5_mem_we", a_if.mem_we, 0);
      chk("s2_c5_mem_wdata_held", a_if.mem_wdata, 32'hDEAD);
      chk("s2_c5_dm_valid", a_if.dm_valid, 0);
      repeat (2) tick();
      chk("s2_c7_if_valid", a_if.if_valid, 0);
      tick();
      chk("s2_c8_if_valid", a_if.if_valid, 1);
      chk("s2_c8_if_rdata", a_if.if_rdata, 32'h153);
      a_if.if_req = 0;
      tick();

      // Fetch blocked by flush in IDLE, then flushed while busy
      a_if.if_req = 1; a_if.if_flush = 1; a_if.if_addr = 32'h200;
      tick();
      chk("s3_idle_flush_no_accept", a_if.mem_en, 0);
      a_if.if_flush = 0;
      tick();
      chk("s3_c1_mem_en", a_if.mem_en, 1);
      chk("s3_c1_mem_addr", a_if.mem_addr, 32'h200);
      tick();
      a_if.if_flush = 1;
      tick();
      a_if.if_flush = 0;
      tick();
      chk("s3_c4_if_valid_suppressed", a_if.if_valid, 0);
      chk("s3_c4_if_rdata_kept", a_if.if_rdata, 32'h153);
      a_if.if_addr = 32'h240;
      tick();
      chk("s3_c5_mem_en", a_if.mem_en, 1);
      chk("s3_c5_mem_addr", a_if.mem_addr, 32'h240);
      repeat (3) tick();
      chk("s3_c8_if_valid", a_if.if_valid, 1);
      chk("s3_c8_if_rdata", a_if.if_rdata, 32'h213);
      a_if.if_req = 0;
      tick();

      // Continuous load traffic with fetch held: grants alternate
      a_if.dm_req = 1; a_if.dm_we = 0; a_if.dm_addr = 32'h80;
      a_if.if_req = 1; a_if.if_addr = 32'h40;
      tick();
      chk("s4_c1_mem_en", a_if.mem_en, 1);
      chk("s4_c1_mem_addr", a_if.mem_addr, 32'h80);
      chk("s4_c1_mem_we", a_if.mem_we, 0);
      repeat (3) tick();
      chk("s4_c4_dm_valid", a_if.dm_valid, 1);
      chk("s4_c4_dm_rdata", a_if.dm_rdata, 32'hD3);
      tick();
      chk("s4_c5_mem_en", a_if.mem_en, 1);
      chk("s4_c5_mem_addr", a_if.mem_addr, 32'h40);
      repeat (3) tick();
      chk("s4_c8_if_valid", a_if.if_valid, 1);
      chk("s4_c8_if_rdata", a_if.if_rdata, 32'h13);
      chk("s4_c8_dm_valid", a_if.dm_valid, 0);
      tick();
      chk("s4_c9_mem_en", a_if.mem_en, 1);
      chk("s4_c9_mem_addr", a_if.mem_addr, 32'h80);
      repeat (3) tick();
      chk("s4_c12_dm_valid", a_if.dm_valid, 1);
      tick();
      chk("s4_c13_mem_en", a_if.mem_en, 1);
      chk("s4_c13_mem_addr", a_if.mem_addr, 32'h40);
      a_if.dm_req = 0;
      repeat (3) tick();
      chk("s4_c16_if_valid", a_if.if_valid, 1);
      a_if.if_req = 0;
      tick();

      // Reset in the middle of a load
      a_if.dm_req = 1; a_if.dm_we = 0; a_if.dm_addr = 32'h300;
      tick();
      chk("s5_c1_mem_en", a_if.mem_en, 1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("s5_c3_mem_en", a_if.mem_en, 0);
      chk("s5_c3_mem_we", a_if.mem_we, 0);
      chk("s5_c3_mem_addr", a_if.mem_addr, 0);
      chk("s5_c3_mem_wdata", a_if.mem_wdata, 0);
      chk("s5_c3_dm_valid", a_if.dm_valid, 0);
      chk("s5_c3_dm_rdata", a_if.dm_rdata, 0);
      chk("s5_c3_if_rdata", a_if.if_rdata, 0);
      chk("s5_c3_if_valid", a_if.if_valid, 0);
      tick();
      chk("s5_c4_mem_en", a_if.mem_en, 1);
      chk("s5_c4_mem_addr", a_if.mem_addr, 32'h300);
      chk("s5_c4_dm_valid", a_if.dm_valid, 0);
      repeat (3) tick();
      chk("s5_c7_dm_valid", a_if.dm_valid, 1);
      chk("s5_c7_dm_rdata", a_if.dm_rdata, 32'h353);
      a_if.dm_req = 0;
      tick();

      // MEM_LAT=1: accept-to-valid is 3 cycles
      b_if.if_req = 1; b_if.if_addr = 32'h40;
      tick();
      chk("s6_if_c1_mem_en", b_if.mem_en, 1);
      tick();
      chk("s6_if_c2_if_valid", b_if.if_valid, 0);
      tick();
      chk("s6_if_c3_if_valid", b_if.if_valid, 1);
      chk("s6_if_c3_if_rdata", b_if.if_rdata, 32'h13);
      b_if.if_req = 0;
      tick();
      b_if.dm_req = 1; b_if.dm_we = 0; b_if.dm_addr = 32'h80;
      tick();
      chk("s6_dm_c1_mem_en", b_if.mem_en, 1);
      tick();
      chk("s6_dm_c2_dm_valid", b_if.dm_valid, 0);
      tick();
      chk("s6_dm_c3_dm_valid", b_if.dm_valid, 1);
      chk("s6_dm_c3_dm_rdata", b_if.dm_rdata, 32'hD3);
      b_if.dm_req = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles (legal range 1..15).
REQ-004 SHALL use a single clock and a synchronous, active-high reset; no other clock or asynchronous reset SHALL exist.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch request
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard the fetch (branch redirect)
- dm_req  in  1  data-memory request
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle fetch-complete pulse
- if_stall  out  1  stall IF stage
- dm_rdata  out  DATA_W  load data, registered
- dm_valid  out  1  one-cycle load/store-complete pulse
- dm_stall  out  1  stall MEM stage
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LAT cycles after the mem_en cycle

Function
REQ-006 SHALL implement FSM states IDLE, BUSY_IF and BUSY_DM, plus a down-counter of width clog2(MEM_LAT+1).
REQ-007 In IDLE, on dm_req, SHALL accept DM, latch dm_we/dm_addr/dm_wdata into mem_* and enter BUSY_DM; DM has fixed priority.
REQ-008 In IDLE, on if_req with no dm_req and no if_flush, SHALL accept IF, latch if_addr into mem_addr with mem_we=0 and enter BUSY_IF.
REQ-009 In IDLE, if_req with if_flush high SHALL NOT be accepted in that cycle.
REQ-010 SHALL NOT accept a new request from a requester in the same cycle that requester's valid is high; the other requester is eligible in that cycle.
REQ-011 mem_en SHALL be high for exactly the first BUSY cycle (T) of each access; mem_we SHALL equal the latched dm_we for DM and 0 for IF; mem_addr and mem_wdata SHALL hold their values until the next accept.
REQ-012 The counter SHALL load MEM_LAT on accept and decrement each BUSY cycle; in cycle T+MEM_LAT the block SHALL capture mem_rdata and return to IDLE at the end of that cycle.
REQ-013 x_valid SHALL pulse for one cycle in cycle T+MEM_LAT+1; accept-to-valid latency SHALL therefore be MEM_LAT+2 cycles.
REQ-014 dm_rdata SHALL update only on load completion; stores SHALL pulse dm_valid and leave dm_rdata unchanged.
REQ-015 if_flush high in any BUSY_IF cycle SHALL cause the access to complete with if_valid suppressed and if_rdata unchanged. The flush SHALL be remembered until completion.
REQ-016 Deassertion of a request or a change of address while BUSY SHALL be ignored; the access SHALL complete normally.
REQ-017 if_stall SHALL equal if_req && !if_valid; dm_stall SHALL equal dm_req && !dm_valid. Both are combinational from the current state.
REQ-018 A requester SHALL hold req and address stable until its valid pulse; the arbiter does not check this.
REQ-019 IF SHALL NOT starve under back-to-back DM traffic, because REQ-010 grants IF in each dm_valid cycle.

Reset
REQ-020 While rst is high at a rising edge: state SHALL go to IDLE, the counter and flush-pending flag SHALL clear, and mem_en, mem_we, if_valid and dm_valid SHALL go to 0. mem_addr, mem_wdata, if_rdata and dm_rdata SHALL go to 0.
REQ-021 Reset during BUSY SHALL abandon the access with no valid pulse. A request held high after reset SHALL be accepted in the first IDLE cycle.

Verification (MEM_LAT=2, request cycle = 0)
REQ-022 Lone IF at addr 0x40 -> mem_en=1 and mem_addr=0x40 in cycle 1; mem_rdata=0x13 in cycle 3; if_valid=1 and if_rdata=0x13 in cycle 4; if_stall=1 in cycles 0-3.
REQ-023 dm_req store (0x80, 0xDEAD) and if_req both in cycle 0 -> mem_we=1 in cycle 1; dm_valid in cycle 4; IF accepted in cycle 4 with mem_en in cycle 5; if_valid in cycle 8.
REQ-024 IF accepted, then if_flush pulsed in cycle 2 -> no if_valid in cycle 4 and if_rdata unchanged; a new IF with flush low in cycle 4 is accepted.
REQ-025 Continuous dm_req with if_req held -> grants alternate DM, IF, DM, IF; no gap beyond the single valid cycle.
REQ-026 rst asserted in cycle 2 of a DM load -> no dm_valid; all outputs 0 in cycle 3; a held dm_req is re-accepted in the first IDLE cycle.
REQ-027 MEM_LAT=1 sweep -> accept-to-valid latency is 3 cycles for both requesters.
